// File: rtl/rv_wb_pkg.sv
// rv_wb_pkg: shared arbiter state encoding and Wishbone constants
package rv_wb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_INSTR, ARB_DATA} arb_state_t;
    localparam logic [3:0]  WB_SEL_ALL  = 4'hF;
    localparam logic [31:0] WB_ERR_DATA = 32'h0;
endpackage

// File: rtl/rv_wb_timeout.sv
// rv_wb_timeout: bus watchdog counting un-acked cycles since the last grant
module rv_wb_timeout #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clr,
    input  logic i_run,
    output logic o_expire
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] wcnt;
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) wcnt <= '0;
        else if (i_clr) wcnt <= '0;
        else if (i_run) wcnt <= wcnt + W'(1);
    assign o_expire = wcnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/rv_wb_arbiter.sv
// rv_wb_arbiter: registered Wishbone arbiter for fetch and data ports with
// data priority, fetch anti-starvation and a bus-timeout watchdog
module rv_wb_arbiter
    import rv_wb_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR       = 32'h0000_0000,
    parameter int          IADDR_SPACE_BITS = 16,
    parameter int          DATA_MAX_RUN     = 4,
    parameter int          TIMEOUT_CYCLES   = 256
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_instr_req,
    input  logic [IADDR_SPACE_BITS-1:0] i_instr_addr,
    output logic                        o_instr_ack,
    output logic [31:0]                 o_instr_data,
    input  logic                        i_data_req,
    input  logic                        i_data_write,
    input  logic [31:0]                 i_data_addr,
    input  logic [31:0]                 i_data_wdata,
    input  logic [3:0]                  i_data_sel,
    output logic                        o_data_ack,
    output logic [31:0]                 o_data_rdata,
    output logic [31:0]                 o_wb_adr,
    output logic [31:0]                 o_wb_dat,
    output logic                        o_wb_we,
    output logic [3:0]                  o_wb_sel,
    output logic                        o_wb_stb,
    output logic                        o_wb_cyc,
    input  logic [31:0]                 i_wb_dat,
    input  logic                        i_wb_ack,
    output logic                        o_bus_err
);
    localparam int RW = $clog2(DATA_MAX_RUN + 1);
    arb_state_t   state, state_nx;
    logic [RW-1:0] run;
    logic busy, tmo_expire, expire, done, run_max, take_data, grant_d, grant_i;
    logic [31:0] rd;
    assign busy      = state != ARB_IDLE;
    assign run_max   = run == RW'(DATA_MAX_RUN);
    assign take_data = i_data_req & ~(i_instr_req & run_max);
    assign grant_d   = ~busy & take_data;
    assign grant_i   = ~busy & ~take_data & i_instr_req;
    assign expire    = busy & ~i_wb_ack & tmo_expire;
    assign done      = busy & (i_wb_ack | expire);
    always_comb begin
        state_nx = state;
        if (!busy) state_nx = grant_d ? ARB_DATA : grant_i ? ARB_INSTR : ARB_IDLE;
        else if (done) state_nx = ARB_IDLE;
    end
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) begin
            state    <= ARB_IDLE;
            run      <= '0;
            o_wb_cyc <= 1'b0;
            o_wb_adr <= '0;
            o_wb_dat <= '0;
            o_wb_we  <= 1'b0;
            o_wb_sel <= '0;
        end else begin
            state <= state_nx;
            if (grant_d) begin
                o_wb_cyc <= 1'b1;
                o_wb_adr <= i_data_addr;
                o_wb_dat <= i_data_wdata;
                o_wb_we  <= i_data_write;
                o_wb_sel <= i_data_sel;
                run      <= i_instr_req ? (run_max ? run : run + RW'(1)) : '0;
            end else if (grant_i) begin
                o_wb_cyc <= 1'b1;
                o_wb_adr <= {RESET_ADDR[31:IADDR_SPACE_BITS], i_instr_addr};
                o_wb_dat <= '0;
                o_wb_we  <= 1'b0;
                o_wb_sel <= WB_SEL_ALL;
                run      <= '0;
            end else if (done) begin
                o_wb_cyc <= 1'b0;
                o_wb_we  <= 1'b0;
            end
        end
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            rv_wb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
                .i_clk    (i_clk),
                .i_reset_n(i_reset_n),
                .i_clr    (grant_d | grant_i),
                .i_run    (busy & ~i_wb_ack),
                .o_expire (tmo_expire)
            );
        end else begin : g_no_wdog
            assign tmo_expire = 1'b0;
        end
    endgenerate
    assign rd           = expire ? WB_ERR_DATA : i_wb_dat;
    assign o_instr_ack  = done & (state == ARB_INSTR);
    assign o_data_ack   = done & (state == ARB_DATA);
    assign o_instr_data = o_instr_ack ? rd : '0;
    assign o_data_rdata = o_data_ack ? rd : '0;
    assign o_wb_stb     = o_wb_cyc;
    assign o_bus_err    = expire;
endmodule

// File: tb/tb_rv_wb_arbiter.sv
// tb_rv_wb_arbiter: directed self-checking bench for rv_wb_arbiter
module tb_rv_wb_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        instr_req = 1'b0, instr_ack;
    logic [15:0] instr_addr = '0;
    logic [31:0] instr_data;
    logic        data_req = 1'b0, data_write = 1'b0, data_ack;
    logic [31:0] data_addr = '0, data_wdata = '0, data_rdata;
    logic [3:0]  data_sel = '0;
    logic [31:0] wb_adr, wb_dat, wb_rdat = '0;
    logic        wb_we, wb_stb, wb_cyc, wb_ack = 1'b0, bus_err;
    logic [3:0]  wb_sel;
    int checks = 0, failures = 0;
    string pattern = "DDDDIDDDDI";
    always #5 clk = ~clk;
    rv_wb_arbiter #(
        .RESET_ADDR(32'h0000_0000), .IADDR_SPACE_BITS(16),
        .DATA_MAX_RUN(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_instr_req(instr_req), .i_instr_addr(instr_addr),
        .o_instr_ack(instr_ack), .o_instr_data(instr_data),
        .i_data_req(data_req), .i_data_write(data_write), .i_data_addr(data_addr),
        .i_data_wdata(data_wdata), .i_data_sel(data_sel),
        .o_data_ack(data_ack), .o_data_rdata(data_rdata),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_we(wb_we), .o_wb_sel(wb_sel),
        .o_wb_stb(wb_stb), .o_wb_cyc(wb_cyc),
        .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack), .o_bus_err(bus_err)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        repeat (2) tick();
        chk("rst_cyc", {31'd0, wb_cyc}, 32'd0);
        chk("rst_stb", {31'd0, wb_stb}, 32'd0);
        chk("rst_adr", wb_adr, 32'd0);
        chk("rst_acks", {30'd0, instr_ack, data_ack}, 32'd0);
        chk("rst_err", {31'd0, bus_err}, 32'd0);
        rst_n = 1'b1;
        // fetch only
        instr_req = 1'b1; instr_addr = 16'h0040;
        tick();
        chk("f_cyc", {31'd0, wb_cyc}, 32'd1);
        chk("f_adr", wb_adr, 32'h0000_0040);
        chk("f_sel", {28'd0, wb_sel}, 32'hF);
        chk("f_we", {31'd0, wb_we}, 32'd0);
        chk("f_noack", {31'd0, instr_ack}, 32'd0);
        wb_ack = 1'b1; wb_rdat = 32'hCAFE_0001;
        #1;
        chk("f_ack", {31'd0, instr_ack}, 32'd1);
        chk("f_data", instr_data, 32'hCAFE_0001);
        chk("f_dack", {31'd0, data_ack}, 32'd0);
        tick();
        instr_req = 1'b0; wb_ack = 1'b0;
        #1;
        chk("f_cyc_off", {31'd0, wb_cyc}, 32'd0);
        chk("f_ack_off", {31'd0, instr_ack}, 32'd0);
        // stray ack in IDLE is ignored
        wb_ack = 1'b1;
        #1;
        chk("idle_acks", {30'd0, instr_ack, data_ack}, 32'd0);
        wb_ack = 1'b0;
        // store
        data_req = 1'b1; data_write = 1'b1; data_addr = 32'h1000_0008;
        data_wdata = 32'hDEAD_BEEF; data_sel = 4'h3;
        tick();
        chk("s_adr", wb_adr, 32'h1000_0008);
        chk("s_dat", wb_dat, 32'hDEAD_BEEF);
        chk("s_we", {31'd0, wb_we}, 32'd1);
        chk("s_sel", {28'd0, wb_sel}, 32'h3);
        chk("s_stb", {31'd0, wb_stb}, 32'd1);
        wb_ack = 1'b1;
        #1;
        chk("s_ack", {31'd0, data_ack}, 32'd1);
        chk("s_iack", {31'd0, instr_ack}, 32'd0);
        tick();
        data_req = 1'b0; data_write = 1'b0; wb_ack = 1'b0;
        #1;
        chk("s_cyc_off", {31'd0, wb_cyc}, 32'd0);
        chk("s_we_off", {31'd0, wb_we}, 32'd0);
        chk("s_ack_off", {31'd0, data_ack}, 32'd0);
        // starvation: both held high
        data_req = 1'b1; data_sel = 4'hF; instr_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("st_adr%0d", i), wb_adr,
                pattern[i] == "D" ? 32'h1000_0008 : 32'h0000_0040);
            wb_ack = 1'b1; wb_rdat = 32'h100 + i;
            #1;
            chk($sformatf("st_ack%0d", i), {30'd0, instr_ack, data_ack},
                pattern[i] == "D" ? 32'd1 : 32'd2);
            tick();
            wb_ack = 1'b0;
        end
        data_req = 1'b0; instr_req = 1'b0;
        tick();
        // simultaneous requests with run=0
        data_req = 1'b1; instr_req = 1'b1;
        tick();
        chk("sim_first", wb_adr, 32'h1000_0008);
        wb_ack = 1'b1;
        #1;
        chk("sim_dack", {30'd0, instr_ack, data_ack}, 32'd1);
        tick();
        data_req = 1'b0; wb_ack = 1'b0;
        tick();
        chk("sim_second", wb_adr, 32'h0000_0040);
        wb_ack = 1'b1; wb_rdat = 32'h0BAD_F00D;
        #1;
        chk("sim_iack", {30'd0, instr_ack, data_ack}, 32'd2);
        chk("sim_idata", instr_data, 32'h0BAD_F00D);
        tick();
        instr_req = 1'b0; wb_ack = 1'b0;
        tick();
        // timeout: slave never acks
        wb_rdat = 32'h1234_5678;
        data_req = 1'b1;
        tick();
        for (int k = 1; k < 8; k++) begin
            chk($sformatf("to_wait%0d", k), {29'd0, bus_err, data_ack, wb_cyc}, 32'd1);
            tick();
        end
        chk("to_ack", {31'd0, data_ack}, 32'd1);
        chk("to_err", {31'd0, bus_err}, 32'd1);
        chk("to_data", data_rdata, 32'd0);
        chk("to_iack", {31'd0, instr_ack}, 32'd0);
        tick();
        data_req = 1'b0;
        #1;
        chk("to_cyc_off", {30'd0, wb_cyc, bus_err}, 32'd0);
        tick();
        // ack on the timeout cycle wins
        data_req = 1'b1;
        tick();
        repeat (7) tick();
        wb_ack = 1'b1;
        #1;
        chk("tw_ack", {31'd0, data_ack}, 32'd1);
        chk("tw_err", {31'd0, bus_err}, 32'd0);
        chk("tw_data", data_rdata, 32'h1234_5678);
        tick();
        data_req = 1'b0; wb_ack = 1'b0;
        #1;
        chk("tw_cyc_off", {31'd0, wb_cyc}, 32'd0);
        tick();
        // reset mid-transaction
        instr_req = 1'b1;
        tick();
        chk("r_cyc_on", {31'd0, wb_cyc}, 32'd1);
        wb_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("r_cyc", {31'd0, wb_cyc}, 32'd0);
        chk("r_stb", {31'd0, wb_stb}, 32'd0);
        chk("r_ack", {30'd0, instr_ack, data_ack}, 32'd0);
        wb_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("r2_cyc", {31'd0, wb_cyc}, 32'd1);
        chk("r2_adr", wb_adr, 32'h0000_0040);
        wb_ack = 1'b1; wb_rdat = 32'h5555_AAAA;
        #1;
        chk("r2_ack", {31'd0, instr_ack}, 32'd1);
        chk("r2_data", instr_data, 32'h5555_AAAA);
        tick();
        instr_req = 1'b0; wb_ack = 1'b0;
        #1;
        chk("r2_cyc_off", {31'd0, wb_cyc}, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
